// File: rtl/systolic_feeder_pkg.sv
// systolic_feeder_pkg: shared types and constants
// for the systolic array operand feeder.
package systolic_feeder_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  localparam int A_W    = 8;
  localparam int LEFT_W = 9;
  localparam int B_W    = 8;

  // Cycles for the last skewed element to cross the grid.
  function automatic int drain_len(
    input int rows,
    input int cols
  );
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_delay.sv
// skew_delay: DEPTH-stage data+valid register chain,
// data forced to zero whenever valid is low.
module skew_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  logic [W-1:0] w_in;

  assign w_in = i_vld ? i_data : '0;

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_data = w_in;
    end else begin : g_chain
      logic [DEPTH-1:0][W-1:0] r_d;
      logic [DEPTH-1:0]        r_v;

      // Shift data and valid one stage per cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_d <= '0;
          r_v <= '0;
        end else begin
          r_d[0] <= w_in;
          r_v[0] <= i_vld;
          for (int s = 1; s < DEPTH; s++) begin
            r_d[s] <= r_d[s-1];
            r_v[s] <= r_v[s-1];
          end
        end
      end

      assign o_data = r_v[DEPTH-1] ? r_d[DEPTH-1] : '0;
    end
  endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: fetches A columns / B rows and drives
// skewed edge streams plus row clears into the PE grid.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic [LEFT_W-1:0]      input_offset,
  output logic                   a_ren,
  output logic [KW-1:0]          a_addr,
  input  logic [ROWS*A_W-1:0]    a_rdata,
  output logic                   b_ren,
  output logic [KW-1:0]          b_addr,
  input  logic [COLS*B_W-1:0]    b_rdata,
  output logic [ROWS*LEFT_W-1:0] left_out,
  output logic [COLS*B_W-1:0]    top_out,
  output logic [ROWS-1:0]        pe_rst_out,
  output logic                   busy,
  output logic                   done
);

  localparam int DONE_CNT = drain_len(ROWS, COLS) + 1;

  state_t            r_state;
  state_t            w_next;
  logic [KW-1:0]     r_cnt;
  logic [KW-1:0]     r_klen;
  logic [LEFT_W-1:0] r_off;
  logic              r_vld;
  logic              r_first;
  logic              r_zdone;
  logic              w_fetch;
  logic              w_done;
  logic              w_last_k;

  assign w_last_k = (r_cnt == r_klen - KW'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and fetch/done decode.
  always_comb begin
    w_next  = r_state;
    w_fetch = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && (k_len != '0))
          w_next = S_FETCH;
      end
      S_FETCH: begin
        w_fetch = 1'b1;
        if (w_last_k) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_cnt == KW'(DONE_CNT)) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Job parameters, k/drain counter, read-return tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_klen  <= '0;
      r_off   <= '0;
      r_vld   <= 1'b0;
      r_first <= 1'b0;
      r_zdone <= 1'b0;
    end else begin
      r_vld   <= w_fetch;
      r_first <= w_fetch && (r_cnt == '0);
      r_zdone <= (r_state == S_IDLE) && start
                 && (k_len == '0);
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (start) begin
            r_klen <= k_len;
            r_off  <= input_offset;
          end
        end
        S_FETCH: r_cnt <= w_last_k ? '0 : r_cnt + KW'(1);
        S_DRAIN: r_cnt <= r_cnt + KW'(1);
        default: r_cnt <= '0;
      endcase
    end
  end

  assign a_ren  = w_fetch;
  assign b_ren  = w_fetch;
  assign a_addr = w_fetch ? r_cnt : '0;
  assign b_addr = w_fetch ? r_cnt : '0;
  assign busy   = (r_state != S_IDLE) && !w_done;
  assign done   = w_done | r_zdone;

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [LEFT_W-1:0] w_sum;
      logic [LEFT_W:0]   w_lo;
      assign w_sum = {a_rdata[gi*A_W+A_W-1],
                      a_rdata[gi*A_W +: A_W]} + r_off;
      skew_delay #(
        .DEPTH(gi),
        .W    (LEFT_W + 1)
      ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_vld (r_vld),
        .i_data({r_first, w_sum}),
        .o_data(w_lo)
      );
      assign left_out[gi*LEFT_W +: LEFT_W] = w_lo[LEFT_W-1:0];
      assign pe_rst_out[gi] = w_lo[LEFT_W];
    end

    for (gi = 0; gi < COLS; gi++) begin : g_col
      skew_delay #(
        .DEPTH(gi),
        .W    (B_W)
      ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_vld (r_vld),
        .i_data(b_rdata[gi*B_W +: B_W]),
        .o_data(top_out[gi*B_W +: B_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: cycle scoreboard of all feeder
// outputs, offset vector table, and a 4x4 PE golden check.
module tb_systolic_feeder;

  localparam int R = 4;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   k_len = '0;
  logic [8:0]   input_offset = '0;
  logic         a_ren, b_ren, busy, done;
  logic [7:0]   a_addr, b_addr;
  logic [R*8-1:0] a_rdata = '0;
  logic [C*8-1:0] b_rdata = '0;
  logic [R*9-1:0] left_out;
  logic [C*8-1:0] top_out;
  logic [R-1:0]   pe_rst_out;

  systolic_feeder #(.ROWS(R), .COLS(C), .KW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .k_len(k_len), .input_offset(input_offset),
    .a_ren(a_ren), .a_addr(a_addr), .a_rdata(a_rdata),
    .b_ren(b_ren), .b_addr(b_addr), .b_rdata(b_rdata),
    .left_out(left_out), .top_out(top_out),
    .pe_rst_out(pe_rst_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [7:0] amem [256][R];
  logic signed [7:0] bmem [256][C];

  always @(posedge clk) begin
    if (a_ren)
      for (int i = 0; i < R; i++)
        a_rdata[i*8 +: 8] <= amem[a_addr][i];
    if (b_ren)
      for (int j = 0; j < C; j++)
        b_rdata[j*8 +: 8] <= bmem[b_addr][j];
  end

  typedef struct packed {
    logic [R*9-1:0] left;
    logic [C*8-1:0] top;
    logic [R-1:0]   rst;
    logic           aren;
    logic [7:0]     aaddr;
    logic           bren;
    logic [7:0]     baddr;
    logic           busy;
    logic           done;
  } obs_t;

  typedef struct {
    int unsigned cyc;
    obs_t        o;
  } rec_t;

  rec_t sb[$];
  int errs = 0;
  int checks = 0;

  function automatic logic [8:0] lval(
    input logic signed [7:0] a,
    input logic [8:0] off
  );
    return {a[7], a} + off;
  endfunction

  task automatic push_job(
    input int unsigned s,
    input int K,
    input logic [8:0] off
  );
    rec_t r;
    int unsigned dc;
    int k;
    dc = (K == 0) ? s + 1 : s + R + C + K + 1;
    for (int unsigned c = s + 1; c <= dc; c++) begin
      r.cyc = c;
      r.o = '0;
      r.o.done = (c == dc);
      r.o.busy = (K != 0) && (c != dc);
      if (K != 0 && c <= s + K) begin
        r.o.aren = 1'b1;
        r.o.bren = 1'b1;
        r.o.aaddr = 8'(c - s - 1);
        r.o.baddr = 8'(c - s - 1);
      end
      for (int i = 0; i < R; i++) begin
        k = int'(c) - int'(s) - 2 - i;
        if (k >= 0 && k < K) begin
          r.o.left[i*9 +: 9] = lval(amem[k][i], off);
          if (k == 0) r.o.rst[i] = 1'b1;
        end
      end
      for (int j = 0; j < C; j++) begin
        k = int'(c) - int'(s) - 2 - j;
        if (k >= 0 && k < K)
          r.o.top[j*8 +: 8] = bmem[k][j];
      end
      sb.push_back(r);
    end
  endtask

  // Compare every output every cycle; idle cycles expect zero.
  always @(negedge clk) begin : mon
    obs_t act;
    obs_t expv;
    act = {left_out, top_out, pe_rst_out, a_ren, a_addr,
           b_ren, b_addr, busy, done};
    expv = '0;
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      expv = sb[0].o;
      void'(sb.pop_front());
    end
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL outputs cycle %0d: got %h expected %h",
               cyc, act, expv);
    end
  end

  // Behavioural 4x4 output-stationary PE grid.
  logic signed [8:0] lr [R][C];
  logic signed [7:0] tr [R][C];
  logic              rr [R][C];
  int                acc [R][C];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        if (!rst_n) begin
          lr[i][j] <= '0; tr[i][j] <= '0;
          rr[i][j] <= 1'b0; acc[i][j] <= 0;
        end else begin
          if (j == 0) begin
            lr[i][j] <= left_out[i*9 +: 9];
            rr[i][j] <= pe_rst_out[i];
          end else begin
            lr[i][j] <= lr[i][j-1];
            rr[i][j] <= rr[i][j-1];
          end
          if (i == 0) tr[i][j] <= top_out[j*8 +: 8];
          else        tr[i][j] <= tr[i-1][j];
          if (rr[i][j])
            acc[i][j] <= int'(lr[i][j]) * int'(tr[i][j]);
          else
            acc[i][j] <= acc[i][j]
                         + int'(lr[i][j]) * int'(tr[i][j]);
        end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_to(input int unsigned c);
    while (cyc < c) step();
  endtask

  task automatic check(
    input string nm,
    input logic [63:0] got,
    input logic [63:0] expv
  );
    checks++;
    if (got !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, expv);
    end
  endtask

  task automatic launch(
    input int K,
    input logic [8:0] off,
    output int unsigned s
  );
    k_len = 8'(K);
    input_offset = off;
    start = 1'b1;
    s = cyc;
    push_job(s, K, off);
    step();
    start = 1'b0;
  endtask

  task automatic wait_empty(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL job timeout: %0d records left, need 0",
               sb.size());
      sb.delete();
    end
  endtask

  typedef struct {
    logic signed [7:0] a;
    logic [8:0]        off;
    logic [8:0]        expv;
  } vec_t;

  vec_t tbl [6];
  int   refm [R][C];

  initial begin : main
    int unsigned s;
    int unsigned s2;
    tbl[0] = '{8'sd127,  9'h080, 9'h0FF};
    tbl[1] = '{-8'sd128, 9'h180, 9'h100};
    tbl[2] = '{-8'sd1,   9'h000, 9'h1FF};
    tbl[3] = '{8'sd5,    9'h1FD, 9'h002};
    tbl[4] = '{8'sd0,    9'h1FF, 9'h1FF};
    tbl[5] = '{-8'sd128, 9'h07F, 9'h1FF};

    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < R; i++) amem[k][i] = '0;
      for (int j = 0; j < C; j++) bmem[k][j] = '0;
    end

    repeat (3) step();
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < R; i++) amem[k][i] = 8'(i + k);
      for (int j = 0; j < C; j++) bmem[k][j] = 8'(j - k);
    end
    launch(3, 9'h000, s);
    wait_to(s + 3);
    check("left1_k0", 64'(left_out[9 +: 9]), 64'd1);
    wait_to(s + 4);
    check("top2_k0", 64'(top_out[16 +: 8]), 64'd2);
    wait_to(s + 5);
    check("rst_row3", 64'(pe_rst_out), 64'h8);
    check("left1_k2", 64'(left_out[9 +: 9]), 64'd3);
    wait_to(s + 12);
    check("done_basic", 64'(done), 64'd1);
    wait_empty(40);
    step();

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < R; i++) amem[0][i] = tbl[t].a;
      launch(1, tbl[t].off, s);
      wait_to(s + 2);
      check($sformatf("offset_vec%0d", t),
            64'(left_out[0 +: 9]), 64'(tbl[t].expv));
      wait_to(s + 3);
      check($sformatf("offset_pad%0d", t),
            64'(left_out[0 +: 9]), 64'd0);
      wait_empty(40);
      step();
    end

    launch(0, 9'h005, s);
    check("k0_done", 64'(done), 64'd1);
    wait_empty(10);
    repeat (2) step();

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < R; i++) amem[k][i] = 8'($urandom);
      for (int j = 0; j < C; j++) bmem[k][j] = 8'($urandom);
    end
    launch(5, 9'h003, s);
    wait_to(s + 3);
    start = 1'b1;
    k_len = 8'd9;
    input_offset = 9'h04D;
    step();
    start = 1'b0;
    wait_empty(40);
    check("busy_job_done_cyc", 64'(cyc), 64'(s + 14));
    step();
    launch(5, 9'h003, s2);
    check("b2b_start_cyc", 64'(s2), 64'(s + 15));
    wait_empty(40);
    check("b2b_done_cyc", 64'(cyc), 64'(s2 + 14));
    step();

    launch(4, 9'h000, s);
    wait_to(s + 2);
    rst_n = 1'b0;
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    launch(4, 9'h001, s);
    wait_empty(40);
    repeat (2) step();

    for (int k = 0; k < 255; k++) begin
      for (int i = 0; i < R; i++) amem[k][i] = 8'($urandom);
      for (int j = 0; j < C; j++) bmem[k][j] = 8'($urandom);
    end
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        refm[i][j] = 0;
        for (int k = 0; k < 255; k++)
          refm[i][j] += (int'(amem[k][i]) + 128)
                        * int'(bmem[k][j]);
      end
    launch(255, 9'h080, s);
    wait_empty(400);
    check("golden_done", 64'(done), 64'd1);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        check($sformatf("acc_%0d_%0d", i, j),
              64'(acc[i][j]), 64'(refm[i][j]));
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit side of the systolic array's data interface: reads operand columns of A and rows of B from the local operand buffers.
- Applies the input offset to A and drives diagonally skewed left/top streams, plus per-row accumulator-clear pulses, into the PE grid edge.
- Signals done once every PE accumulator holds its final dot product.
- Sits between the operand buffers and the ROWS x COLS PE array.

Parameters:
- ROWS, 4, PE array rows; one 9-bit left stream each.
- COLS, 4, PE array columns; one 8-bit top stream each.
- KW, 8, width of k_len and of the buffer address.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle launch pulse; ignored unless idle
- k_len  in  KW  reduction depth K; latched at start
- input_offset  in  9  signed offset added to each A byte; latched at start
- a_ren  out  1  A buffer read enable
- a_addr  out  KW  A buffer address (k index)
- a_rdata  in  ROWS*8  A column k; byte i = a[i][k], signed; valid 1 cycle after a_ren
- b_ren  out  1  B buffer read enable
- b_addr  out  KW  B buffer address (k index)
- b_rdata  in  COLS*8  B row k; byte j = b[k][j], signed; valid 1 cycle after b_ren
- left_out  out  ROWS*9  signed left stream; slice i drives row i, column 0
- top_out  out  COLS*8  signed top stream; slice j drives row 0, column j
- pe_rst_out  out  ROWS  accumulator clear for row i; the PE row chain carries it rightwards with the data
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when all accumulators are final

Behaviour:
- Reset (async, rst_n low): all outputs 0, FSM in IDLE, delay lines cleared.
- Reset mid-operation aborts immediately; outputs return to 0 and there is no done pulse.
- FSM states IDLE, FETCH, DRAIN.
- IDLE: start=1 at cycle s latches k_len and input_offset.
  - If k_len != 0, go to FETCH.
  - If k_len == 0, pulse done at s+1, never raise busy, and issue no reads or pe_rst.
- FETCH, cycles s+1 .. s+K:
  - a_ren = b_ren = 1; a_addr = b_addr = k for k = 0..K-1.
  - Then go to DRAIN.
- DRAIN: counter runs; done pulses at cycle s+ROWS+COLS+K+1, busy drops in the same cycle, then return to IDLE.
- Define t0 = s+2, the cycle the first read data returns.
- Left stream: row i presents a[i][k] at cycle t0+i+k.
  - Value = sign-extended byte + latched offset, truncated to 9 bits (two's-complement wrap).
- Top stream: column j presents b[k][j] at cycle t0+j+k.
- Skew: row i is delayed i extra cycles and column j is delayed j extra cycles, using register delay lines.
  - A valid bit travels with the data; when the valid bit is low, the output slice is 0 (the offset is not applied to padding).
- pe_rst_out[i] = 1 only at cycle t0+i, aligned with the k=0 element of row i; 0 otherwise.
- Result: PE(i,j) acc is final at cycle t0+i+j+K+1; done marks the last PE, (ROWS-1, COLS-1).
- start while busy is ignored; k_len and input_offset changes while busy are ignored.
- start is accepted in the cycle after done (IDLE). Trailing skewed zeros from the prior job may overlap the new job's t0 window only as zeros and never corrupt it.
- k_len max = 2^KW-1; the address never wraps within a job.

Decomposition:
- Shared package: FSM state enum; constants A_W=8, LEFT_W=9, B_W=8; DRAIN_LEN = ROWS+COLS-1 expressed as a function.
- Sub-module skew_delay (parameters DEPTH, W): DEPTH-stage register chain carrying data and valid, zeroing data when valid is low, DEPTH=0 meaning pass-through.
  - Instantiated per row and per column.

Test Plan:
- Reset: rst_n low mid-FETCH with K=4 -> next cycle all outputs 0, busy 0, no done; a fresh start afterwards completes normally.
- Basic 4x4, K=3, offset=0, a[i][k]=i+k, b[k][j]=j-k:
  - left_out[1] = 1,2,3 at t0+1..t0+3; top_out[2] = 2,1,0 at t0+2..t0+4.
  - pe_rst_out[3] at t0+3 only; done at s+12.
- Offset wrap: a=127, offset=+128 -> left slice = 255 (9'h0FF); a=-128, offset=-128 -> 9'h100 (wrap); padding cycles output 0.
- k_len=0 -> done at s+1, a_ren never asserted, pe_rst_out stays 0, busy stays 0.
- start pulsed at s+3 while busy (K=5) -> ignored, single done at s+14; back-to-back start at the done+1 cycle -> second job timing identical relative to its own s.
- Golden end-to-end: feeder driving a 4x4 PE array, K=255 random int8, offset=128 -> all 16 acc values at done match the reference matmul sum((a+128)*b).
